// File: rtl/mcp2515_spi_master.sv
// Byte-stream SPI master (mode 1,1, MSB first) that frames one CS-low transaction
// of 1..31 bytes to an MCP2515, pulling tx bytes from a show-ahead source.
`timescale 1ns/1ps
module mcp2515_spi_master #(
  parameter int HALF_DIV = 200,
  parameter int CS_SETUP = 100,
  parameter int CS_IDLE  = 500
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] len,
  input  logic [7:0] tx_data,
  output logic       tx_ld,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       cs,
  output logic       sck,
  output logic       si,
  input  logic       so,
  output logic [2:0] dbg_state
);

  // Handshake: start is taken only in a cycle where busy=0 and len!=0; tx_ld marks
  // the cycle tx_data is consumed (next byte must show the cycle after); rx_valid
  // qualifies rx_data for exactly one cycle per byte; done marks the cycle cs rises.

  localparam int SPAN_A = (CS_SETUP > 2 * HALF_DIV) ? CS_SETUP : 2 * HALF_DIV;
  localparam int SPAN   = (SPAN_A > CS_IDLE) ? SPAN_A : CS_IDLE;
  localparam int CW     = $clog2(SPAN + 1);

  localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] RISE_AT    = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] BIT_LAST   = CW'(2 * HALF_DIV - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HALF_DIV - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [4:0]    r_bytes;
  logic          r_more;
  logic [7:0]    r_shift;
  logic [7:0]    r_rx;
  logic [7:0]    r_rx_data;
  logic          r_rx_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_cs;
  logic          r_sck;
  logic          r_si;

  logic w_accept;
  logic w_fall;
  logic w_rise;
  logic w_byte_end;
  logic w_load;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_fall      = 1'b0;
    w_rise      = 1'b0;
    w_byte_end  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (len != 5'd0)) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == SETUP_LAST) begin
          w_fall      = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_cnt == RISE_AT) begin
          w_rise     = 1'b1;
          w_byte_end = (r_bit == 3'd7);
          w_load     = (r_bit == 3'd7) && (r_bytes != 5'd0);
        end
        // r_more was captured at this byte's last rise: it says whether a next byte follows
        if (r_cnt == BIT_LAST) begin
          if ((r_bit == 3'd7) && !r_more) w_state_nxt = S_HOLD;
          else                            w_fall      = 1'b1;
        end
      end
      S_HOLD: begin
        if (r_cnt == HOLD_LAST) w_state_nxt = S_GAP;
      end
      S_GAP: begin
        if (r_cnt == GAP_LAST) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk50) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_bit      <= 3'd0;
      r_bytes    <= 5'd0;
      r_more     <= 1'b0;
      r_shift    <= 8'h00;
      r_rx       <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cs       <= 1'b1;
      r_sck      <= 1'b1;
      r_si       <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_done     <= 1'b0;

      if ((r_state == S_IDLE) || (r_state != w_state_nxt) || w_fall) r_cnt <= '0;
      else                                                           r_cnt <= r_cnt + 1'b1;

      if (w_accept) begin
        r_shift <= tx_data;
        r_bytes <= len - 5'd1;
        r_bit   <= 3'd0;
        r_cs    <= 1'b0;
        r_busy  <= 1'b1;
      end

      if (w_fall) begin
        r_sck   <= 1'b0;
        r_si    <= r_shift[7];
        r_shift <= {r_shift[6:0], 1'b0};
      end

      if (w_rise) begin
        r_sck <= 1'b1;
        r_rx  <= {r_rx[6:0], so};
      end

      if (w_byte_end) begin
        r_rx_data  <= {r_rx[6:0], so};
        r_rx_valid <= 1'b1;
        r_more     <= (r_bytes != 5'd0);
      end

      if (w_load) begin
        r_shift <= tx_data;
        r_bytes <= r_bytes - 5'd1;
      end

      if ((r_state == S_SHIFT) && (r_cnt == BIT_LAST)) r_bit <= r_bit + 3'd1;

      if ((r_state == S_SHIFT) && (w_state_nxt == S_HOLD)) r_si <= 1'b0;

      if ((r_state == S_HOLD) && (w_state_nxt == S_GAP)) begin
        r_cs   <= 1'b1;
        r_done <= 1'b1;
      end

      if ((r_state == S_GAP) && (w_state_nxt == S_IDLE)) r_busy <= 1'b0;
    end
  end

  assign tx_ld     = rst_n && (w_accept || w_load);
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cs        = r_cs;
  assign sck       = r_sck;
  assign si        = r_si;
  assign dbg_state = r_state;

endmodule
